// File: rtl/sfq_dfft_bank.sv
// sfq_dfft_bank: behavioural timing model of WIDTH RSFQ DFFT cells on a shared clock line
module sfq_dfft_bank #(
  parameter int  WIDTH             = 4,
  parameter int  MODE              = 0,
  parameter real DELAY_CLK_OUT     = 7.7,
  parameter real CT_STATE0_CLK_SET = 1.6,
  parameter real CT_STATE1_CLK_SET = 0.9,
  parameter real CT_SET_CLK        = 0.0,
  parameter real STEADY_T          = 4.0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] set,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] err,
  output logic [15:0]      viol_count
);
  timeunit 1ps;
  timeprecision 100fs;
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] err_q;
  logic [WIDTH-1:0] set_prev;
  logic             clk_prev;
  logic [15:0]      viol_q;
  int unsigned      gen_q [WIDTH];
  real              ct_q [WIDTH];
  real              t_set_q [WIDTH];
  real              t_clk_q;
  real              now;
  assign out        = out_q;
  assign err        = err_q;
  assign viol_count = viol_q;
  function automatic bit in_win(input real dt, input real win);
    return longint'(dt * 10.0) < longint'(win * 10.0);
  endfunction
  task automatic violate(input int i);
    out_q[i] = 1'bx;
    err_q[i] = 1'b1;
    if (viol_q != 16'hFFFF) viol_q = viol_q + 16'd1;
    $display("Violation of critical timing in module %m; %0.1f ps.", $realtime);
  endtask
  always @(clk, set, rst_n) begin
    #0;
    now = $realtime;
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        gen_q[i]   = gen_q[i] + 1;
        ct_q[i]    = 0.0;
        t_set_q[i] = -1.0e9;
      end
      state_q = '0;
      out_q   = '0;
      err_q   = '0;
      viol_q  = '0;
      t_clk_q = -1.0e9;
    end else if (now >= STEADY_T) begin
      if (clk != clk_prev) begin
        for (int i = 0; i < WIDTH; i++) begin
          ct_q[i] = state_q[i] ? CT_STATE1_CLK_SET : CT_STATE0_CLK_SET;
          if (CT_SET_CLK > 0.0 && in_win(now - t_set_q[i], CT_SET_CLK)) begin
            violate(i);
          end else if (state_q[i]) begin
            fork
              automatic int k = i;
              automatic int unsigned g = gen_q[i];
              begin
                #(DELAY_CLK_OUT);
                if (gen_q[k] == g && rst_n) out_q[k] = ~out_q[k];
              end
            join_none
            if (MODE == 0) state_q[i] = 1'b0;
          end
        end
        t_clk_q = now;
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (set[i] != set_prev[i]) begin
          if (in_win(now - t_clk_q, ct_q[i])) violate(i);
          else state_q[i] = 1'b1;
          t_set_q[i] = now;
        end
      end
    end
    clk_prev = clk;
    set_prev = set;
  end
endmodule
